// File: rtl/tpu_mem_pkg.sv
// tpu_mem_pkg
//   Shared definitions for matrix_tile_memory and its storage array:
//   tile-engine state encoding, default element width and tile size,
//   and the power-of-two address-wrap helper used by the engine's
//   address generator.
package tpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } tile_state_e;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_TILE_MAX = 32;

    // Reduce an address modulo 2**addr_w (DEPTH is a power of two, so
    // wrapping is a mask rather than a divide).
    function automatic logic [63:0] wrap_addr(input logic [63:0] addr,
                                              input int          addr_w);
        return addr & ((64'd1 << addr_w) - 64'd1);
    endfunction

endpackage

// File: rtl/tile_mem_array.sv
// tile_mem_array
//   DEPTH x DATA_W storage with one write port and two synchronous read
//   ports. A read of the address being written in the same cycle returns
//   the old word. Contents are never reset; only the read registers are.
// Ports:
//   clk, rst            clock, async active-high reset (read regs only)
//   wr_en/wr_addr/wr_data   write port
//   a_en/a_addr -> a_data   host read port, registered, holds when idle
//   b_en/b_addr -> b_data   engine read port, registered, holds when idle
module tile_mem_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              a_en,
    input  logic [ADDR_W-1:0] a_addr,
    output logic [DATA_W-1:0] a_data,
    input  logic              b_en,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] b_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Reads sample mem before this edge's write lands: read-before-write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_data <= '0;
            b_data <= '0;
        end else begin
            if (a_en) a_data <= mem[a_addr];
            if (b_en) b_data <= mem[b_addr];
        end
    end

endmodule

// File: rtl/matrix_tile_memory.sv
// matrix_tile_memory
//   Word-addressed memory with a host read/write port and a tile-read
//   engine that streams an M x N sub-matrix one beat per handshake.
//   Each beat is gathered one word per cycle into a lane buffer, then
//   held on row_* until row_ready.
// Build option:
//   TILE_TRANSPOSE_EN  adds input tile_transpose; when latched high the
//                      tile is streamed column-wise (N beats of M lanes).
// Ports:
//   clk, rst                        clock, async active-high reset
//   wr_en/wr_addr/wr_data           host write
//   rd_en/rd_addr -> rd_data/rd_valid   host read, 1-cycle latency
//   tile_start/base/rows/cols/stride    tile request (sampled in IDLE)
//   tile_busy/tile_done/tile_err        engine status
//   row_valid/row_ready                 beat handshake
//   row_data/row_mask/row_idx/row_last  beat payload
module matrix_tile_memory
    import tpu_mem_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = 1048576,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int TILE_MAX = DEF_TILE_MAX,
    parameter int DIM_W    = $clog2(TILE_MAX) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
`ifdef TILE_TRANSPOSE_EN
    input  logic                       tile_transpose,
`endif
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    input  logic                       tile_start,
    input  logic [ADDR_W-1:0]          tile_base,
    input  logic [DIM_W-1:0]           tile_rows,
    input  logic [DIM_W-1:0]           tile_cols,
    input  logic [ADDR_W-1:0]          tile_stride,
    output logic                       tile_busy,
    output logic                       tile_done,
    output logic                       tile_err,
    output logic                       row_valid,
    input  logic                       row_ready,
    output logic [TILE_MAX*DATA_W-1:0] row_data,
    output logic [TILE_MAX-1:0]        row_mask,
    output logic [DIM_W-1:0]           row_idx,
    output logic                       row_last
);

    tile_state_e state_q, state_d;

    logic [DIM_W-1:0]  rows_q, cols_q, b_q, c_q, land_idx_q;
    logic [ADDR_W-1:0] stride_q, beat_addr_q, ptr_q;
    logic              tr_q, land_vld_q, err_q;
    logic              launch, advance, issue, start_bad, last_beat;
    logic [DIM_W-1:0]  beat_len, beat_cnt;
    logic [ADDR_W-1:0] lane_step, beat_step, ptr_next, beat_next;
    logic [DATA_W-1:0] eng_data;

    logic [TILE_MAX-1:0][DATA_W-1:0] lane_q;
    logic [TILE_MAX-1:0]             lane_mask;

    tile_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .a_en    (rd_en),
        .a_addr  (rd_addr),
        .a_data  (rd_data),
        .b_en    (issue),
        .b_addr  (ptr_q),
        .b_data  (eng_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_valid <= 1'b0;
        else     rd_valid <= rd_en;
    end

    // Row-major: a beat is a row, lanes step by 1, beats step by stride.
    // Transposed: a beat is a column, lanes step by stride, beats by 1.
    assign beat_len  = tr_q ? rows_q : cols_q;
    assign beat_cnt  = tr_q ? cols_q : rows_q;
    assign lane_step = tr_q ? stride_q : ADDR_W'(1);
    assign beat_step = tr_q ? ADDR_W'(1) : stride_q;
    assign ptr_next  = ADDR_W'(wrap_addr(64'(ptr_q) + 64'(lane_step), ADDR_W));
    assign beat_next = ADDR_W'(wrap_addr(64'(beat_addr_q) + 64'(beat_step), ADDR_W));
    assign last_beat = (b_q == beat_cnt - DIM_W'(1));

    assign start_bad = (tile_rows == '0) || (tile_cols == '0) ||
                       (tile_rows > DIM_W'(TILE_MAX)) ||
                       (tile_cols > DIM_W'(TILE_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        tile_busy = 1'b1;
        row_valid = 1'b0;
        tile_done = 1'b0;
        issue     = 1'b0;
        launch    = 1'b0;
        advance   = 1'b0;
        case (state_q)
            IDLE: begin
                tile_busy = 1'b0;
                if (tile_start && !start_bad) begin
                    launch  = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                issue = (c_q < beat_len);
                if (land_vld_q && (land_idx_q == beat_len - DIM_W'(1)))
                    state_d = HOLD;
            end
            HOLD: begin
                row_valid = 1'b1;
                if (row_ready) begin
                    if (last_beat) begin
                        state_d = DONE;
                    end else begin
                        advance = 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                tile_done = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rows_q      <= '0;
            cols_q      <= '0;
            stride_q    <= '0;
            beat_addr_q <= '0;
            ptr_q       <= '0;
            b_q         <= '0;
            c_q         <= '0;
            land_vld_q  <= 1'b0;
            land_idx_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            // Data for the lane issued this cycle arrives next cycle.
            land_vld_q <= issue;
            land_idx_q <= c_q;
            err_q      <= (state_q == IDLE) && tile_start && start_bad;
            if (launch) begin
                rows_q      <= tile_rows;
                cols_q      <= tile_cols;
                stride_q    <= tile_stride;
                beat_addr_q <= tile_base;
                ptr_q       <= tile_base;
                b_q         <= '0;
                c_q         <= '0;
            end else if (advance) begin
                b_q         <= b_q + DIM_W'(1);
                beat_addr_q <= beat_next;
                ptr_q       <= beat_next;
                c_q         <= '0;
            end else if (issue) begin
                ptr_q <= ptr_next;
                c_q   <= c_q + DIM_W'(1);
            end
        end
    end

`ifdef TILE_TRANSPOSE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         tr_q <= 1'b0;
        else if (launch) tr_q <= tile_transpose;
    end
`else
    assign tr_q = 1'b0;
`endif

    // Lanes are cleared at the start of every beat so lanes past the
    // beat length read back as zero.
    for (genvar k = 0; k < TILE_MAX; k++) begin : g_lane
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                lane_q[k] <= '0;
            else if (launch || advance)
                lane_q[k] <= '0;
            else if (land_vld_q && (land_idx_q == DIM_W'(k)))
                lane_q[k] <= eng_data;
        end
        assign lane_mask[k] = (DIM_W'(k) < beat_len);
    end

    assign row_data = lane_q;
    assign row_mask = row_valid ? lane_mask : '0;
    assign row_idx  = b_q;
    assign row_last = row_valid && last_beat;
    assign tile_err = err_q;

endmodule

// File: tb/tb_matrix_tile_memory.sv
`timescale 1ns/1ps
module tb_matrix_tile_memory;

    localparam int DATA_W   = 16;
    localparam int DEPTH    = 1024;
    localparam int ADDR_W   = 10;
    localparam int TILE_MAX = 8;
    localparam int DIM_W    = 4;
    localparam int RW       = TILE_MAX * DATA_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              tile_transpose = 1'b0;
    logic              wr_en = 1'b0, rd_en = 1'b0, tile_start = 1'b0, row_ready = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0, rd_addr = '0, tile_base = '0, tile_stride = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic [DIM_W-1:0]  tile_rows = '0, tile_cols = '0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid, tile_busy, tile_done, tile_err, row_valid, row_last;
    logic [RW-1:0]     row_data;
    logic [TILE_MAX-1:0] row_mask;
    logic [DIM_W-1:0]  row_idx;

    always #5 clk = ~clk;

    matrix_tile_memory #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
        .TILE_MAX(TILE_MAX), .DIM_W(DIM_W)
    ) dut (
        .clk(clk), .rst(rst),
`ifdef TILE_TRANSPOSE_EN
        .tile_transpose(tile_transpose),
`endif
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .tile_start(tile_start), .tile_base(tile_base), .tile_rows(tile_rows),
        .tile_cols(tile_cols), .tile_stride(tile_stride),
        .tile_busy(tile_busy), .tile_done(tile_done), .tile_err(tile_err),
        .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
        .row_mask(row_mask), .row_idx(row_idx), .row_last(row_last)
    );

    logic [DATA_W-1:0] mem_m [DEPTH];
    int vectors = 0;
    int errors  = 0;

    function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
        logic              re;
        logic [ADDR_W-1:0] ra;
        logic              ev;
        logic [DATA_W-1:0] ed;
    } hvec_t;

    hvec_t tbl [8];

    task automatic check_all_zero(input string tag);
        chk({tag, "_rd_data"},   256'(rd_data),   '0);
        chk({tag, "_rd_valid"},  256'(rd_valid),  '0);
        chk({tag, "_busy"},      256'(tile_busy), '0);
        chk({tag, "_done"},      256'(tile_done), '0);
        chk({tag, "_err"},       256'(tile_err),  '0);
        chk({tag, "_row_valid"}, 256'(row_valid), '0);
        chk({tag, "_row_data"},  256'(row_data),  '0);
        chk({tag, "_row_mask"},  256'(row_mask),  '0);
        chk({tag, "_row_idx"},   256'(row_idx),   '0);
        chk({tag, "_row_last"},  256'(row_last),  '0);
    endtask

    // Streams one tile and checks every beat against mem_m.
    // stall < 0 picks a random stall per beat.
    task automatic run_tile(input int base, input int rows, input int cols,
                            input int stride, input logic tr, input int stall);
        int blen, bcnt, n, st, r, c, a;
        logic [RW-1:0]       exp_data;
        logic [TILE_MAX-1:0] exp_mask;
        blen = tr ? rows : cols;
        bcnt = tr ? cols : rows;
        tile_base      = ADDR_W'(base);
        tile_rows      = DIM_W'(rows);
        tile_cols      = DIM_W'(cols);
        tile_stride    = ADDR_W'(stride);
        tile_transpose = tr;
        tile_start     = 1'b1;
        row_ready      = 1'b0;
        for (int b = 0; b < bcnt; b++) begin
            @(negedge clk);
            tile_start = 1'b0;
            n = 1;
            if (b == 0) chk("busy_after_start", 256'(tile_busy), 256'(1));
            while (!row_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (!row_valid) begin
                chk("beat_timeout", 256'(row_valid), 256'(1));
                return;
            end
            if (b == 0) chk("first_beat_latency", 256'(n), 256'(blen + 2));
            exp_data = '0;
            exp_mask = '0;
            for (int l = 0; l < blen; l++) begin
                r = tr ? l : b;
                c = tr ? b : l;
                a = (base + r * stride + c) % DEPTH;
                exp_data[l*DATA_W +: DATA_W] = mem_m[a];
                exp_mask[l] = 1'b1;
            end
            chk("row_data", 256'(row_data), 256'(exp_data));
            chk("row_mask", 256'(row_mask), 256'(exp_mask));
            chk("row_idx",  256'(row_idx),  256'(b));
            chk("row_last", 256'(row_last), 256'(b == bcnt - 1));
            st = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
            for (int s = 0; s < st; s++) begin
                // A start request while the engine is busy must be ignored.
                if (s == 0) begin
                    tile_start = 1'b1;
                    tile_rows  = '0;
                end
                @(negedge clk);
                tile_start = 1'b0;
                chk("stall_valid", 256'(row_valid), 256'(1));
                chk("stall_data",  256'(row_data),  256'(exp_data));
                chk("stall_idx",   256'(row_idx),   256'(b));
                chk("stall_no_err", 256'(tile_err), '0);
            end
            row_ready = 1'b1;
            @(negedge clk);
            row_ready = 1'b0;
            chk("valid_gap", 256'(row_valid), '0);
            chk("done_timing", 256'(tile_done), 256'(b == bcnt - 1));
        end
        @(negedge clk);
        chk("done_single", 256'(tile_done), '0);
        chk("idle_after",  256'(tile_busy), '0);
    endtask

    task automatic err_tile(input int rows, input int cols);
        tile_rows   = DIM_W'(rows);
        tile_cols   = DIM_W'(cols);
        tile_base   = '0;
        tile_stride = ADDR_W'(1);
        tile_start  = 1'b1;
        @(negedge clk);
        tile_start = 1'b0;
        chk("err_pulse", 256'(tile_err),  256'(1));
        chk("err_busy",  256'(tile_busy), '0);
        chk("err_valid", 256'(row_valid), '0);
        @(negedge clk);
        chk("err_clear", 256'(tile_err),  '0);
        chk("err_busy2", 256'(tile_busy), '0);
        chk("err_valid2", 256'(row_valid), '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    initial begin
        logic [DATA_W-1:0] exp_d, d;
        logic              exp_v, done_seen;
        int                n;

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Preload: low words hold their own address, the rest random.
        for (int i = 0; i < DEPTH; i++) begin
            d = (i < 64) ? DATA_W'(i) : DATA_W'($urandom);
            wr_en = 1'b1; wr_addr = ADDR_W'(i); wr_data = d;
            mem_m[i] = d;
            @(negedge clk);
        end
        wr_en = 1'b0;

        // Host port vectors: inputs for one cycle, rd_* seen the next.
        tbl[0] = '{1'b1, 10'd5, 16'hBEEF, 1'b0, 10'd0, 1'b0, 16'h0000};
        tbl[1] = '{1'b0, 10'd0, 16'h0000, 1'b1, 10'd5, 1'b1, 16'hBEEF};
        tbl[2] = '{1'b1, 10'd5, 16'h1234, 1'b1, 10'd5, 1'b1, 16'hBEEF};
        tbl[3] = '{1'b0, 10'd0, 16'h0000, 1'b0, 10'd0, 1'b0, 16'hBEEF};
        tbl[4] = '{1'b0, 10'd0, 16'h0000, 1'b1, 10'd5, 1'b1, 16'h1234};
        tbl[5] = '{1'b1, 10'd7, 16'hAAAA, 1'b1, 10'd6, 1'b1, 16'h0006};
        tbl[6] = '{1'b0, 10'd0, 16'h0000, 1'b1, 10'd7, 1'b1, 16'hAAAA};
        tbl[7] = '{1'b1, 10'd7, 16'h0007, 1'b1, 10'd5, 1'b1, 16'h1234};
        for (int i = 0; i < 8; i++) begin
            wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
            rd_en = tbl[i].re; rd_addr = tbl[i].ra;
            if (tbl[i].we) mem_m[tbl[i].wa] = tbl[i].wd;
            @(negedge clk);
            wr_en = 1'b0; rd_en = 1'b0;
            chk("host_rd_valid", 256'(rd_valid), 256'(tbl[i].ev));
            chk("host_rd_data",  256'(rd_data),  256'(tbl[i].ed));
        end
        wr_en = 1'b1; wr_addr = 10'd5; wr_data = 16'd5; mem_m[5] = 16'd5;
        @(negedge clk);
        wr_en = 1'b0;

        // Directed tiles.
        run_tile(0, 2, 2, 8, 1'b0, 0);
        run_tile(0, 2, 2, 8, 1'b0, 5);
        run_tile(DEPTH - 1, 1, 2, 1, 1'b0, 0);
        run_tile(3, 3, TILE_MAX, 9, 1'b0, 1);
        err_tile(0, 2);
        err_tile(2, 0);
        err_tile(2, TILE_MAX + 1);
        err_tile(TILE_MAX + 1, 2);
`ifdef TILE_TRANSPOSE_EN
        run_tile(0, 2, 2, 8, 1'b1, 0);
        run_tile(4, 3, 5, 10, 1'b1, 2);
`endif

        // Reset during the second beat's fetch.
        tile_base = '0; tile_rows = 4'd2; tile_cols = 4'd2; tile_stride = 10'd8;
        tile_transpose = 1'b0; row_ready = 1'b0; tile_start = 1'b1;
        @(negedge clk);
        tile_start = 1'b0;
        n = 0;
        while (!row_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_seq_beat0", 256'(row_valid), 256'(1));
        row_ready = 1'b1;
        @(negedge clk);
        row_ready = 1'b0;
        chk("rst_seq_fetch_busy", 256'(tile_busy), 256'(1));
        rst = 1'b1;
        #1;
        check_all_zero("midtile_rst");
        done_seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (tile_done) done_seen = 1'b1;
        end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (tile_done) done_seen = 1'b1;
        end
        chk("no_done_after_rst", 256'(done_seen), '0);
        run_tile(0, 2, 2, 8, 1'b0, 0);

        // Random host traffic against the array model.
        exp_d = rd_data;
        for (int i = 0; i < 80; i++) begin
            wr_en = 1'($urandom); wr_addr = ADDR_W'($urandom); wr_data = DATA_W'($urandom);
            rd_en = 1'($urandom);
            rd_addr = (i % 4 == 0) ? wr_addr : ADDR_W'($urandom);
            exp_v = rd_en;
            if (rd_en) exp_d = mem_m[rd_addr];
            if (wr_en) mem_m[wr_addr] = wr_data;
            @(negedge clk);
            wr_en = 1'b0; rd_en = 1'b0;
            chk("rand_rd_valid", 256'(rd_valid), 256'(exp_v));
            chk("rand_rd_data",  256'(rd_data),  256'(exp_d));
        end

        // Random tiles with random back-pressure.
        for (int i = 0; i < 15; i++) begin
            logic tr;
`ifdef TILE_TRANSPOSE_EN
            tr = 1'($urandom);
`else
            tr = 1'b0;
`endif
            run_tile(int'($urandom_range(0, DEPTH - 1)),
                     int'($urandom_range(1, TILE_MAX)),
                     int'($urandom_range(1, TILE_MAX)),
                     int'($urandom_range(0, DEPTH - 1)), tr, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
